// File: rtl/dmem_pkg.sv
// Shared types and constants for the byte-strobed data memory.
package dmem_pkg;

   // Controller states: zeroing the array after reset, then normal service.
   typedef enum logic {
      StClear = 1'b0,
      StRun   = 1'b1
   } state_e;

   localparam int unsigned DefDepthLog2   = 6;
   localparam int unsigned DefMailboxWord = 43;
   localparam int unsigned NumLanes       = 4;

endpackage

// File: rtl/dmem_lane_ram.sv
// One byte lane of the data memory: synchronous write, asynchronous read.
module dmem_lane_ram #(
   parameter int unsigned DEPTH_LOG2 = 6
) (
   input  logic                  iwClk,
   input  logic                  iwWe,
   input  logic [DEPTH_LOG2-1:0] iwWaddr,
   input  logic [7:0]            iwWdata,
   input  logic [DEPTH_LOG2-1:0] iwRaddr,
   output logic [7:0]            owRdata
);

   localparam int unsigned Depth = 1 << DEPTH_LOG2;

   logic [7:0] r_mem [Depth];

   // Storage update; contents are deliberately not reset.
   always_ff @(posedge iwClk) begin
      if (iwWe) begin
         r_mem[iwWaddr] <= iwWdata;
      end
   end

   assign owRdata = r_mem[iwRaddr];

endmodule

// File: rtl/dmem_strb.sv
// Byte-strobed data memory with post-reset clear sequencer and a mailbox word.
module dmem_strb
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2   = DefDepthLog2,
   parameter int unsigned MAILBOX_WORD = DefMailboxWord,
   parameter bit          INIT_CLEAR   = 1'b1
) (
   input  logic                iwClk,
   input  logic                iwnRst,
   input  logic [31:0]         iwReadAddr,
   input  logic [31:0]         iwWriteAddr,
   input  logic [31:0]         iwWriteData,
   input  logic [NumLanes-1:0] iwWstrb,
   output logic [31:0]         owReadData,
   output logic [31:0]         owMailbox,
   output logic                owMailboxStrobe,
   output logic                owReady
);

   localparam int unsigned         Depth      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LastWord   = (DEPTH_LOG2 + 1)'(Depth - 1);
   localparam state_e              ResetState = INIT_CLEAR ? StClear : StRun;

   state_e                r_state;
   logic [DEPTH_LOG2:0]   r_clr_cnt;
   logic [31:0]           r_mailbox;
   logic                  r_mb_strobe;

   logic [NumLanes-1:0]   w_we;
   logic [DEPTH_LOG2-1:0] w_waddr;
   logic [DEPTH_LOG2-1:0] w_raddr;
   logic [31:0]           w_wdata;
   logic [31:0]           w_rdata;
   logic                  w_mb_hit;
   logic [31:0]           w_mb_next;
   logic                  w_unused_addr;

   // Byte-offset bits and out-of-range read bits play no part in array access.
   assign w_unused_addr = ^{iwReadAddr[31:DEPTH_LOG2+2], iwReadAddr[1:0], iwWriteAddr[1:0]};

   // Write-port mux: clear sequencer owns the array until RUN; reset blocks all writes.
   always_comb begin
      w_raddr = iwReadAddr[DEPTH_LOG2+1:2];
      if (r_state == StClear) begin
         w_we    = {NumLanes{iwnRst}};
         w_waddr = r_clr_cnt[DEPTH_LOG2-1:0];
         w_wdata = '0;
      end else begin
         w_we    = iwWstrb & {NumLanes{iwnRst}};
         w_waddr = iwWriteAddr[DEPTH_LOG2+1:2];
         w_wdata = iwWriteData;
      end
   end

   for (genvar gn = 0; gn < NumLanes; gn++) begin : g_lane
      dmem_lane_ram #(
         .DEPTH_LOG2(DEPTH_LOG2)
      ) u_ram (
         .iwClk  (iwClk),
         .iwWe   (w_we[gn]),
         .iwWaddr(w_waddr),
         .iwWdata(w_wdata[8*gn +: 8]),
         .iwRaddr(w_raddr),
         .owRdata(w_rdata[8*gn +: 8])
      );
   end

   // Mailbox decode uses the full word address, so aliases of the word do not hit.
   always_comb begin
      w_mb_hit  = (r_state == StRun) && (iwWstrb != '0) &&
                  (iwWriteAddr[31:2] == 30'(MAILBOX_WORD));
      w_mb_next = r_mailbox;
      for (int n = 0; n < NumLanes; n++) begin
         if (iwWstrb[n]) begin
            w_mb_next[8*n +: 8] = iwWriteData[8*n +: 8];
         end
      end
   end

   // Controller: one pass of DEPTH clear writes, then park in RUN.
   always_ff @(posedge iwClk or negedge iwnRst) begin
      if (!iwnRst) begin
         r_state   <= ResetState;
         r_clr_cnt <= '0;
      end else begin
         case (r_state)
            StClear: begin
               r_clr_cnt <= r_clr_cnt + 1'b1;
               if (r_clr_cnt == LastWord) begin
                  r_state <= StRun;
               end
            end
            StRun:   r_state <= StRun;
            default: r_state <= ResetState;
         endcase
      end
   end

   // Mailbox shadow register and its one-cycle-per-write strobe.
   always_ff @(posedge iwClk or negedge iwnRst) begin
      if (!iwnRst) begin
         r_mailbox   <= '0;
         r_mb_strobe <= 1'b0;
      end else begin
         r_mb_strobe <= w_mb_hit;
         if (w_mb_hit) begin
            r_mailbox <= w_mb_next;
         end
      end
   end

   assign owReady         = (r_state == StRun);
   assign owReadData      = (r_state == StRun) ? w_rdata : '0;
   assign owMailbox       = r_mailbox;
   assign owMailboxStrobe = r_mb_strobe;

endmodule

// File: tb/tb_dmem_strb.sv
// Scoreboard bench for dmem_strb: byte-level reference model, queued expectations.
module tb_dmem_strb;

   localparam int unsigned MbWord = 43;

   logic        iwClk;
   logic        iwnRst;
   logic [31:0] iwReadAddr;
   logic [31:0] iwWriteAddr;
   logic [31:0] iwWriteData;
   logic [3:0]  iwWstrb;
   logic [31:0] owReadData;
   logic [31:0] owMailbox;
   logic        owMailboxStrobe;
   logic        owReady;

   dmem_strb u_dut (
      .iwClk          (iwClk),
      .iwnRst         (iwnRst),
      .iwReadAddr     (iwReadAddr),
      .iwWriteAddr    (iwWriteAddr),
      .iwWriteData    (iwWriteData),
      .iwWstrb        (iwWstrb),
      .owReadData     (owReadData),
      .owMailbox      (owMailbox),
      .owMailboxStrobe(owMailboxStrobe),
      .owReady        (owReady)
   );

   initial iwClk = 1'b0;
   always #5 iwClk = ~iwClk;

   typedef struct {
      int          due;
      logic [31:0] rd;
   } rd_exp_t;

   typedef struct {
      int          due;
      logic        strb;
      logic [31:0] mb;
   } mb_exp_t;

   rd_exp_t rd_q[$];
   mb_exp_t mb_q[$];

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   // Reference model: 64 words viewed as 256 bytes; mailbox kept as its own value.
   logic [7:0]  m_mem [256];
   logic [31:0] m_mb;

   always @(posedge iwClk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
      m_mb = 32'h0;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int base;
      base = int'(a[7:2]) * 4;
      return {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
   endfunction

   // Applies one RUN cycle of traffic and queues what the DUT must show for it.
   task automatic drive(input logic [31:0] ra, input logic [31:0] wa,
                        input logic [31:0] wd, input logic [3:0] ws);
      rd_exp_t r;
      mb_exp_t m;
      int      base;
      iwReadAddr  = ra;
      iwWriteAddr = wa;
      iwWriteData = wd;
      iwWstrb     = ws;
      r.due = cyc;
      r.rd  = model_read(ra);
      rd_q.push_back(r);
      base = int'(wa[7:2]) * 4;
      for (int n = 0; n < 4; n++) if (ws[n]) m_mem[base+n] = wd[8*n +: 8];
      m.strb = (ws != 4'b0000) && (wa[31:2] == 30'(MbWord));
      if (m.strb) begin
         for (int n = 0; n < 4; n++) if (ws[n]) m_mb[8*n +: 8] = wd[8*n +: 8];
      end
      m.due = cyc + 1;
      m.mb  = m_mb;
      mb_q.push_back(m);
      @(posedge iwClk);
      #1;
   endtask

   task automatic idle();
      drive(32'h0, 32'h0, 32'h0, 4'b0000);
   endtask

   // Counts rising edges until owReady, bounded so a stuck clear still ends.
   task automatic wait_ready(output int n);
      n = 0;
      while (!owReady && n < 200) begin
         @(posedge iwClk);
         #1;
         n++;
      end
   endtask

   // Monitor: compare every queued expectation that falls due this cycle.
   always @(negedge iwClk) begin : mon
      rd_exp_t r;
      mb_exp_t m;
      while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
         r = rd_q.pop_front();
         chk("read_data", owReadData, r.rd);
      end
      while (mb_q.size() > 0 && mb_q[0].due <= cyc) begin
         m = mb_q.pop_front();
         chk("mailbox_strobe", {31'b0, owMailboxStrobe}, {31'b0, m.strb});
         chk("mailbox_value", owMailbox, m.mb);
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got stuck, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int          n;
      logic [31:0] wa;
      logic [31:0] ra;
      iwnRst      = 1'b0;
      iwReadAddr  = 32'h0;
      iwWriteAddr = 32'h0;
      iwWriteData = 32'h0;
      iwWstrb     = 4'b0000;
      model_clear();

      repeat (3) @(posedge iwClk);
      #1;
      chk("reset_ready", {31'b0, owReady}, 32'h0);
      chk("reset_mailbox", owMailbox, 32'h0);
      chk("reset_strobe", {31'b0, owMailboxStrobe}, 32'h0);

      // A full-strobe write held throughout the clear must be ignored.
      iwWriteAddr = 32'h20;
      iwWriteData = 32'hFFFF_FFFF;
      iwWstrb     = 4'b1111;
      iwReadAddr  = 32'h20;
      iwnRst      = 1'b1;
      #1;
      chk("clear_read_zero", owReadData, 32'h0);
      wait_ready(n);
      iwWstrb = 4'b0000;
      chk("clear_cycles", 32'(n), 32'd64);
      chk("clear_strobe_quiet", {31'b0, owMailboxStrobe}, 32'h0);
      chk("post_clear_0x20", owReadData, 32'h0);

      for (int w = 0; w < 64; w++) drive(32'(w * 4), 32'h0, 32'h0, 4'b0000);

      // Byte merge.
      drive(32'h0, 32'h10, 32'h1122_3344, 4'b1111);
      drive(32'h0, 32'h10, 32'hAABB_CCDD, 4'b0101);
      drive(32'h10, 32'h0, 32'h0, 4'b0000);
      #1;
      chk("byte_merge", owReadData, 32'h11BB_33DD);

      // Mailbox write: one strobe cycle, value mirrored in array.
      drive(32'hAC, 32'hAC, 32'hCAFE_F00D, 4'b1111);
      chk("mb_strobe_high", {31'b0, owMailboxStrobe}, 32'h1);
      chk("mb_value", owMailbox, 32'hCAFE_F00D);
      drive(32'hAC, 32'h0, 32'h0, 4'b0000);
      chk("mb_strobe_once", {31'b0, owMailboxStrobe}, 32'h0);
      chk("mb_array_copy", owReadData, 32'hCAFE_F00D);

      // Alias of the mailbox word: array changes, mailbox does not.
      drive(32'hAC, 32'h1AC, 32'h1234_5678, 4'b1111);
      chk("alias_no_strobe", {31'b0, owMailboxStrobe}, 32'h0);
      chk("alias_mb_hold", owMailbox, 32'hCAFE_F00D);
      chk("alias_array", owReadData, 32'h1234_5678);
      idle();

      // Back-to-back mailbox writes with partial strobes and byte offsets.
      drive(32'hAC, 32'hAC, 32'h0000_0001, 4'b1111);
      drive(32'hAC, 32'hAE, 32'h0000_2200, 4'b0010);
      drive(32'hAC, 32'hAD, 32'h3300_0000, 4'b1000);
      chk("b2b_strobe", {31'b0, owMailboxStrobe}, 32'h1);
      chk("b2b_value", owMailbox, 32'h3300_2201);
      idle();
      idle();

      // Random traffic, biased toward the mailbox word and its aliases.
      for (int i = 0; i < 500; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: wa = {30'(MbWord), 2'($urandom)};
            3:       wa = {24'($urandom), 6'(MbWord), 2'($urandom)};
            default: wa = $urandom;
         endcase
         ra = ($urandom_range(0, 1) == 0) ? wa : $urandom;
         drive(ra, wa, $urandom, 4'($urandom));
      end

      drive(32'hAC, 32'hAC, 32'hDEAD_BEEF, 4'b1111);
      idle();
      idle();
      repeat (2) @(posedge iwClk);
      #1;
      chk("rd_queue_drained", 32'(rd_q.size()), 32'h0);
      chk("mb_queue_drained", 32'(mb_q.size()), 32'h0);

      // Reset mid-run clears the mailbox asynchronously; then reset at clear cycle 30.
      iwnRst = 1'b0;
      #1;
      chk("async_rst_mailbox", owMailbox, 32'h0);
      chk("async_rst_ready", {31'b0, owReady}, 32'h0);
      @(posedge iwClk);
      #1;
      iwnRst = 1'b1;
      repeat (30) @(posedge iwClk);
      #1;
      chk("mid_clear_not_ready", {31'b0, owReady}, 32'h0);
      iwnRst = 1'b0;
      @(posedge iwClk);
      #1;
      iwnRst = 1'b1;
      wait_ready(n);
      chk("reclear_cycles", 32'(n), 32'd64);
      chk("reclear_mailbox", owMailbox, 32'h0);
      model_clear();
      drive(32'hAC, 32'h0, 32'h0, 4'b0000);
      drive(32'h10, 32'h0, 32'h0, 4'b0000);
      drive(32'h20, 32'h0, 32'h0, 4'b0000);
      idle();
      repeat (2) @(posedge iwClk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
